// File: rtl/vend_pkg.sv
// Shared types and helpers for the parametrised vending controller.
//   state_e         : controller state encoding (IDLE..CHANGE)
//   clog2_w()       : select-field width, never narrower than 1 bit
//   DEF_CHANGE_UNIT : default value of one ejected change coin
package vend_pkg;

  localparam int unsigned STATE_W         = 3;
  localparam int unsigned DEF_CHANGE_UNIT = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_CHECK  = 3'd2,
    ST_VEND   = 3'd3,
    ST_CHANGE = 3'd4
  } state_e;

  // Width of an index selecting one of n entries (minimum 1 bit).
  function automatic int unsigned clog2_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vend_fsm_param_if.sv
// Coin/keypad request side and dispense/display status side of the controller.
//   master : input sync layer + display/dispense drivers (drive requests, observe status)
//   slave  : vend_fsm_param (consume requests, drive registered status/pulses)
interface vend_fsm_param_if
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned N_COIN   = 4,
  parameter int unsigned N_PROD   = 8
);
  localparam int unsigned COIN_SEL_W = clog2_w(N_COIN);
  localparam int unsigned PROD_SEL_W = clog2_w(N_PROD);

  logic                         coin;
  logic [COIN_SEL_W-1:0]        coin_sel;
  logic [N_COIN*CREDIT_W-1:0]   coin_val_tbl;
  logic                         check;
  logic [PROD_SEL_W-1:0]        prod_sel;
  logic [N_PROD*CREDIT_W-1:0]   price_tbl;
  logic                         cancel;
  logic [STATE_W-1:0]           state;
  logic [CREDIT_W-1:0]          credit;
  logic                         dispense;
  logic [PROD_SEL_W-1:0]        dispense_id;
  logic                         change_pulse;
  logic                         deny;
  logic                         overflow;

  modport master (
    output coin, coin_sel, coin_val_tbl, check, prod_sel, price_tbl, cancel,
    input  state, credit, dispense, dispense_id, change_pulse, deny, overflow
  );

  modport slave (
    input  coin, coin_sel, coin_val_tbl, check, prod_sel, price_tbl, cancel,
    output state, credit, dispense, dispense_id, change_pulse, deny, overflow
  );

endinterface

// File: rtl/vend_timeout_ctr.sv
// Idle-cycle counter for the ACCEPT state.
//   clk, rst : clock, asynchronous active-high reset
//   i_clr    : synchronous clear (wins over i_en)
//   i_en     : count one idle cycle
//   o_tc_c   : combinational terminal count, high while count == TIMEOUT-1
module vend_timeout_ctr
  import vend_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);
  localparam int unsigned CNT_W = clog2_w(TIMEOUT);

  logic [CNT_W-1:0] r_cnt;

  // Count register; never runs past TIMEOUT-1 because the FSM clears on expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_tc_c = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: accumulates coin credit, checks it against a
// per-product price, dispenses, and pays change one CHANGE_UNIT coin per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of vend_fsm_param_if (coin/check/cancel requests in,
//              registered state/credit/dispense/change/deny/overflow out)
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned N_COIN      = 4,
  parameter int unsigned N_PROD      = 8,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned CHANGE_UNIT = DEF_CHANGE_UNIT
) (
  input  logic           clk,
  input  logic           rst,
  vend_fsm_param_if.slave bus
);
  localparam int unsigned PROD_SEL_W = clog2_w(N_PROD);
  localparam logic [CREDIT_W-1:0] UNIT = CREDIT_W'(CHANGE_UNIT);

  state_e                r_state,        w_state_n;
  logic [CREDIT_W-1:0]   r_credit,       w_credit_n;
  logic                  r_dispense,     w_dispense_n;
  logic [PROD_SEL_W-1:0] r_dispense_id,  w_dispense_id_n;
  logic                  r_change_pulse, w_change_pulse_n;
  logic                  r_deny,         w_deny_n;
  logic                  r_overflow,     w_overflow_n;

  logic [CREDIT_W-1:0]   w_coin_val;
  logic [CREDIT_W-1:0]   w_price;
  logic [CREDIT_W:0]     w_sum;
  logic                  w_tmr_clr;
  logic                  w_tmr_en;
  logic                  w_tmr_tc;

  assign w_coin_val = bus.coin_val_tbl[32'(bus.coin_sel) * CREDIT_W +: CREDIT_W];
  assign w_price    = bus.price_tbl[32'(r_dispense_id) * CREDIT_W +: CREDIT_W];
  // Carry bit flags a coin that would wrap the credit register.
  assign w_sum      = {1'b0, r_credit} + {1'b0, w_coin_val};

  vend_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tmr_clr),
    .i_en   (w_tmr_en),
    .o_tc_c (w_tmr_tc)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_credit       <= '0;
      r_dispense     <= 1'b0;
      r_dispense_id  <= '0;
      r_change_pulse <= 1'b0;
      r_deny         <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_credit       <= w_credit_n;
      r_dispense     <= w_dispense_n;
      r_dispense_id  <= w_dispense_id_n;
      r_change_pulse <= w_change_pulse_n;
      r_deny         <= w_deny_n;
      r_overflow     <= w_overflow_n;
    end
  end

  // Next state and next output values; pulses default low each cycle.
  always_comb begin
    w_state_n        = r_state;
    w_credit_n       = r_credit;
    w_dispense_n     = 1'b0;
    w_dispense_id_n  = r_dispense_id;
    w_change_pulse_n = 1'b0;
    w_deny_n         = 1'b0;
    w_overflow_n     = 1'b0;
    w_tmr_clr        = 1'b1;
    w_tmr_en         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.coin) begin
          if (w_sum[CREDIT_W]) begin
            w_overflow_n = 1'b1;
          end else begin
            w_credit_n = w_sum[CREDIT_W-1:0];
            w_state_n  = ST_ACCEPT;
          end
        end
      end
      ST_ACCEPT: begin
        // cancel > check > coin; timeout only when the customer did nothing.
        if (bus.cancel) begin
          w_state_n = ST_CHANGE;
        end else if (bus.check) begin
          w_dispense_id_n = bus.prod_sel;
          w_state_n       = ST_CHECK;
        end else if (bus.coin) begin
          if (w_sum[CREDIT_W]) w_overflow_n = 1'b1;
          else                 w_credit_n   = w_sum[CREDIT_W-1:0];
        end else if (w_tmr_tc) begin
          w_state_n = ST_CHANGE;
        end else begin
          w_tmr_clr = 1'b0;
          w_tmr_en  = 1'b1;
        end
      end
      ST_CHECK: begin
        if (r_credit >= w_price) begin
          w_credit_n   = r_credit - w_price;
          w_dispense_n = 1'b1;
          w_state_n    = ST_VEND;
        end else begin
          w_deny_n  = 1'b1;
          w_state_n = ST_ACCEPT;
        end
      end
      ST_VEND: begin
        w_state_n = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        // Residual below one change coin is forfeited.
        if (r_credit >= UNIT) begin
          w_change_pulse_n = 1'b1;
          w_credit_n       = r_credit - UNIT;
        end else begin
          w_credit_n = '0;
          w_state_n  = ST_IDLE;
        end
      end
      default: begin
        w_credit_n = '0;
        w_state_n  = ST_IDLE;
      end
    endcase
  end

  assign bus.state        = r_state;
  assign bus.credit       = r_credit;
  assign bus.dispense     = r_dispense;
  assign bus.dispense_id  = r_dispense_id;
  assign bus.change_pulse = r_change_pulse;
  assign bus.deny         = r_deny;
  assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed self-checking bench for vend_fsm_param (TIMEOUT=4, coins {5,10,25,100}).
module tb_vend_fsm_param;
  import vend_pkg::*;

  localparam int unsigned CREDIT_W = 8;
  localparam int unsigned N_COIN   = 4;
  localparam int unsigned N_PROD   = 8;
  localparam int unsigned TIMEOUT  = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   n_pulse;

  vend_fsm_param_if #(.CREDIT_W(CREDIT_W), .N_COIN(N_COIN), .N_PROD(N_PROD)) bus ();

  vend_fsm_param #(
    .CREDIT_W(CREDIT_W), .N_COIN(N_COIN), .N_PROD(N_PROD),
    .TIMEOUT(TIMEOUT), .CHANGE_UNIT(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge with the given strobes; returns 1 time unit after the edge.
  task automatic drive(input logic c, input logic [1:0] cs, input logic k,
                       input logic [2:0] ps, input logic x);
    @(negedge clk);
    bus.coin     = c;
    bus.coin_sel = cs;
    bus.check    = k;
    bus.prod_sel = ps;
    bus.cancel   = x;
    @(posedge clk);
    #1;
    bus.coin   = 1'b0;
    bus.check  = 1'b0;
    bus.cancel = 1'b0;
  endtask

  task automatic idle();               drive(1'b0, 2'd0, 1'b0, 3'd0, 1'b0); endtask
  task automatic coin(input logic [1:0] s); drive(1'b1, s, 1'b0, 3'd0, 1'b0); endtask
  task automatic buy(input logic [2:0] p);  drive(1'b0, 2'd0, 1'b1, p, 1'b0); endtask
  task automatic cancel();             drive(1'b0, 2'd0, 1'b0, 3'd0, 1'b1); endtask

  // Run CHANGE to completion (bounded), counting change coins.
  task automatic drain(input string tag, input int exp_pulses);
    n_pulse = 0;
    for (int i = 0; i < 60; i++) begin
      idle();
      if (bus.change_pulse) n_pulse++;
      if (bus.state == 3'd0) break;
    end
    chk({tag, "_pulses"}, 32'(n_pulse), 32'(exp_pulses));
    chk({tag, "_idle"},   32'(bus.state), 32'd0);
    chk({tag, "_credit"}, 32'(bus.credit), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.coin = 1'b0; bus.coin_sel = '0; bus.check = 1'b0;
    bus.prod_sel = '0; bus.cancel = 1'b0;
    bus.coin_val_tbl = {8'd100, 8'd25, 8'd10, 8'd5};
    bus.price_tbl    = {8'd80, 8'd70, 8'd60, 8'd50, 8'd45, 8'd40, 8'd30, 8'd20};
    #12;
    chk("rst_state",  32'(bus.state), 32'd0);
    chk("rst_credit", 32'(bus.credit), 32'd0);
    chk("rst_pulses", 32'({bus.dispense, bus.change_pulse, bus.deny, bus.overflow}), 32'd0);
    chk("rst_id",     32'(bus.dispense_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Check in IDLE is ignored.
    buy(3'd3);
    chk("idle_check", 32'(bus.state), 32'd0);

    // Basic vend: 25+25, product 3 @45, 5 change.
    coin(2'd2);
    chk("bv_c1_state",  32'(bus.state), 32'd1);
    chk("bv_c1_credit", 32'(bus.credit), 32'd25);
    coin(2'd2);
    chk("bv_c2_credit", 32'(bus.credit), 32'd50);
    buy(3'd3);
    chk("bv_check_state", 32'(bus.state), 32'd2);
    chk("bv_id",          32'(bus.dispense_id), 32'd3);
    idle();
    chk("bv_vend_state", 32'(bus.state), 32'd3);
    chk("bv_dispense",   32'(bus.dispense), 32'd1);
    chk("bv_credit",     32'(bus.credit), 32'd5);
    idle();
    chk("bv_chg_state", 32'(bus.state), 32'd4);
    chk("bv_disp_end",  32'(bus.dispense), 32'd0);
    drain("bv", 1);

    // Deny then successful vend with 13 change coins.
    coin(2'd1);
    buy(3'd3);
    idle();
    chk("dn_deny",   32'(bus.deny), 32'd1);
    chk("dn_state",  32'(bus.state), 32'd1);
    chk("dn_credit", 32'(bus.credit), 32'd10);
    idle();
    chk("dn_deny_end", 32'(bus.deny), 32'd0);
    coin(2'd3);
    chk("dn_credit2", 32'(bus.credit), 32'd110);
    buy(3'd3);
    idle();
    chk("dn_dispense", 32'(bus.dispense), 32'd1);
    chk("dn_credit3",  32'(bus.credit), 32'd65);
    drain("dn", 13);

    // Overflow: 100+100, third 100 rejected.
    coin(2'd3);
    coin(2'd3);
    chk("ov_credit", 32'(bus.credit), 32'd200);
    chk("ov_none",   32'(bus.overflow), 32'd0);
    coin(2'd3);
    chk("ov_flag",    32'(bus.overflow), 32'd1);
    chk("ov_credit2", 32'(bus.credit), 32'd200);
    chk("ov_state",   32'(bus.state), 32'd1);
    idle();
    chk("ov_flag_end", 32'(bus.overflow), 32'd0);
    cancel();
    chk("ov_cancel", 32'(bus.state), 32'd4);
    drain("ov", 40);

    // Timeout: 10 credit, expires after 4 idle cycles.
    coin(2'd1);
    idle(); idle(); idle();
    chk("to_still_accept", 32'(bus.state), 32'd1);
    idle();
    chk("to_change", 32'(bus.state), 32'd4);
    drain("to", 2);

    // Priority: coin with cancel at credit 15 is ignored.
    coin(2'd1);
    coin(2'd0);
    chk("pr_credit", 32'(bus.credit), 32'd15);
    drive(1'b1, 2'd3, 1'b0, 3'd0, 1'b1);
    chk("pr_state",   32'(bus.state), 32'd4);
    chk("pr_credit2", 32'(bus.credit), 32'd15);
    drain("pr", 3);

    // Async reset mid-CHANGE.
    coin(2'd2);
    coin(2'd0);
    cancel();
    chk("ar_credit30", 32'(bus.credit), 32'd30);
    idle();
    chk("ar_pulse", 32'(bus.change_pulse), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_state",  32'(bus.state), 32'd0);
    chk("ar_credit", 32'(bus.credit), 32'd0);
    chk("ar_cp",     32'(bus.change_pulse), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    chk("ar_after", 32'({bus.state, bus.change_pulse}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vend_fsm_param.md
Name: vend_fsm_param

Overview:
- Parametrised successor to the 3-state vending controller.
- Accepts coins of N_COIN denominations, accumulates credit and checks it against a per-product price.
- On success, dispenses the product and returns change one unit-coin per cycle. A timeout returns credit if the customer stalls.
- Sits between the coin/keypad input sync layer and the dispense/display drivers.

Parameters:
- CREDIT_W, 8, width of the credit and price values, in cents-units.
- N_COIN, 4, number of coin denominations; coin_sel width is clog2(N_COIN).
- N_PROD, 8, number of products; prod_sel width is clog2(N_PROD).
- TIMEOUT, 255, idle cycles in ACCEPT before auto-refund (>=1).
- CHANGE_UNIT, 5, value of one change coin ejected per change_pulse.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- coin  in  1  one-cycle strobe: a coin was inserted.
- coin_sel  in  clog2(N_COIN)  denomination index, valid with coin.
- coin_val_tbl  in  N_COIN*CREDIT_W  packed denomination values; entry i is at bits [i*CREDIT_W +: CREDIT_W].
- check  in  1  one-cycle strobe: purchase requested.
- prod_sel  in  clog2(N_PROD)  product index, valid with check.
- price_tbl  in  N_PROD*CREDIT_W  packed price table.
- cancel  in  1  strobe: refund all credit.
- state  out  3  current state encoding.
- credit  out  CREDIT_W  accumulated credit.
- dispense  out  1  one-cycle pulse, product index on dispense_id.
- dispense_id  out  clog2(N_PROD)  product dispensed.
- change_pulse  out  1  one pulse per ejected CHANGE_UNIT coin.
- deny  out  1  one-cycle pulse: insufficient credit.
- overflow  out  1  one-cycle pulse: coin rejected because credit would exceed its maximum.

Behaviour:
- Reset, asynchronous: state=IDLE, credit=0, all pulse outputs 0, timer=0, dispense_id=0.
- States: IDLE=0, ACCEPT=1, CHECK=2, VEND=3, CHANGE=4. Codes 5-7 go to IDLE next cycle with credit cleared.
- Coin acceptance (IDLE or ACCEPT):
  - sum = credit + coin_val_tbl[coin_sel], computed CREDIT_W+1 bits wide.
  - If sum[CREDIT_W]=1: coin rejected, overflow=1 next cycle, credit unchanged.
  - Otherwise credit<=sum; from IDLE, state becomes ACCEPT.
- ACCEPT:
  - The timer increments each cycle with no coin, check or cancel, and clears on any coin.
  - On timer==TIMEOUT-1, or on cancel: go to CHANGE (refund).
  - On check: latch prod_sel into dispense_id, go to CHECK.
- Priority in one cycle: cancel > check > coin. A coin arriving with check or cancel is ignored; no credit is added.
- check or cancel in IDLE is ignored.
- CHECK, one cycle:
  - Price is price_tbl[dispense_id].
  - If credit>=price: credit<=credit-price, go to VEND.
  - Otherwise deny=1 and return to ACCEPT with the timer cleared.
- VEND, one cycle: dispense=1. Go to CHANGE if credit!=0, else IDLE.
- CHANGE:
  - Each cycle with credit>=CHANGE_UNIT: change_pulse=1 and credit-=CHANGE_UNIT.
  - When credit<CHANGE_UNIT: the residual is forfeited, credit<=0, go to IDLE. No pulse is issued that cycle.
- Inputs are ignored in CHECK, VEND and CHANGE; coins there are not credited.
- Latency:
  - Coin to credit update: 1 cycle.
  - check to dispense: 2 cycles, passing through CHECK then VEND.
- All outputs are registered. Pulses last exactly one cycle.
- Reset mid-CHANGE: credit is lost and no further pulses are issued.

Decomposition:
- Package vend_pkg holds:
  - the state enum / localparams (IDLE..CHANGE);
  - a function for clog2 widths;
  - the default CHANGE_UNIT.
- One natural sub-module is vend_timeout_ctr: a parametrised TIMEOUT counter with clear, enable and terminal-count outputs.

Test Plan:
- Basic vend:
  - Stimulus: tables {5,10,25,100}; coin sel2 (25), coin sel2 (25); check prod3 with price 45.
  - Required: credit 25→50; CHECK; dispense=1 with id=3; credit 5; one change_pulse; IDLE with credit 0.
- Deny:
  - Stimulus: coin sel1 (10), then check prod with price 45.
  - Required: deny pulse, back in ACCEPT with credit 10. Then coin sel3 (100), check: dispense, credit 65 → 13 change_pulses.
- Overflow:
  - Stimulus: CREDIT_W=8; insert 100, 100, then 100.
  - Required: credit 200; third coin gives overflow=1 and credit stays 200.
- Timeout:
  - Stimulus: TIMEOUT=4; coin 10, then no activity.
  - Required: CHANGE after 4 idle cycles, 2 change_pulses, IDLE.
- Priority:
  - Stimulus: coin together with cancel while credit is 15.
  - Required: coin ignored; 3 change_pulses; credit 0.
- Async reset:
  - Stimulus: assert rst off-edge during CHANGE with credit 30.
  - Required: state=0, credit=0 and change_pulse=0 immediately, without waiting for a clock edge.
